// File: rtl/dpram_hs.sv
// Dual-port word RAM (instruction + data) with req/gnt/rvalid handshake, byte-lane writes and tohost halt.
// Latency: gnt after WAIT_STATES held cycles, rvalid exactly RD_LATENCY cycles after gnt on both ports.
// Backpressure: none on responses; a requester waits by holding req until gnt, one grant per port per cycle.

module dpram_hs_gnt #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic gnt
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       gnt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        gnt_c = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 3'd1;
                    end
                end
            end
            S_WAIT: begin
                // Dropping req mid-count abandons the request without a response.
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == WS) begin
                    gnt_c     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs read as 0 while reset is held, even if req is already asserted.
    assign gnt = gnt_c & rst_n;
endmodule

module dpram_hs #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          RAM_ADDR_WIDTH = 21,
    parameter int          RD_LATENCY     = 1,
    parameter int          WAIT_STATES    = 0,
    parameter logic [31:0] TOHOST_ADDR    = 32'h1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    i_req_i,
    input  logic [31:0]             i_addr_i,
    output logic                    i_gnt_o,
    output logic                    i_rvalid_o,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    output logic                    i_err_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [31:0]             d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_err_o,
    output logic                    halt_o,
    output logic [DATA_WIDTH-1:0]   halt_code_o
);
    localparam int BW    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BW);
    localparam int IW    = RAM_ADDR_WIDTH - OFF;
    localparam int WORDS = 1 << IW;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    dpram_hs_gnt #(.WAIT_STATES(WAIT_STATES)) u_i_gnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .req   (i_req_i),
        .gnt   (i_gnt_o)
    );

    dpram_hs_gnt #(.WAIT_STATES(WAIT_STATES)) u_d_gnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .req   (d_req_i),
        .gnt   (d_gnt_o)
    );

    logic          i_tohost, d_tohost, i_oor, d_oor;
    logic [IW-1:0] i_idx, d_idx;

    assign i_tohost = (i_addr_i >> OFF) == (TOHOST_ADDR >> OFF);
    assign d_tohost = (d_addr_i >> OFF) == (TOHOST_ADDR >> OFF);
    assign i_oor    = ((i_addr_i >> RAM_ADDR_WIDTH) != 32'd0) && !i_tohost;
    assign d_oor    = ((d_addr_i >> RAM_ADDR_WIDTH) != 32'd0) && !d_tohost;
    assign i_idx    = i_addr_i[RAM_ADDR_WIDTH-1:OFF];
    assign d_idx    = d_addr_i[RAM_ADDR_WIDTH-1:OFF];

    logic [RD_LATENCY-1:0] i_vld_q, i_err_q, d_vld_q, d_err_q;
    logic [DATA_WIDTH-1:0] i_dat_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] d_dat_q [RD_LATENCY];

    // Stage 0 samples the array at the grant edge, so a same-edge write is seen as the old word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i_vld_q <= '0;
            i_err_q <= '0;
            d_vld_q <= '0;
            d_err_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                i_dat_q[s] <= '0;
                d_dat_q[s] <= '0;
            end
        end else begin
            i_vld_q[0] <= i_gnt_o;
            i_err_q[0] <= i_gnt_o & i_oor;
            i_dat_q[0] <= (i_gnt_o && !i_oor) ? mem[i_idx] : '0;
            d_vld_q[0] <= d_gnt_o;
            d_err_q[0] <= d_gnt_o & d_oor;
            d_dat_q[0] <= (d_gnt_o && !d_we_i && !d_oor) ? mem[d_idx] : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                i_vld_q[s] <= i_vld_q[s-1];
                i_err_q[s] <= i_err_q[s-1];
                i_dat_q[s] <= i_dat_q[s-1];
                d_vld_q[s] <= d_vld_q[s-1];
                d_err_q[s] <= d_err_q[s-1];
                d_dat_q[s] <= d_dat_q[s-1];
            end
        end
    end

    assign i_rvalid_o = i_vld_q[RD_LATENCY-1];
    assign i_err_o    = i_err_q[RD_LATENCY-1];
    assign i_rdata_o  = i_dat_q[RD_LATENCY-1];
    assign d_rvalid_o = d_vld_q[RD_LATENCY-1];
    assign d_err_o    = d_err_q[RD_LATENCY-1];
    assign d_rdata_o  = d_dat_q[RD_LATENCY-1];

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (d_gnt_o && d_we_i && !d_oor) begin
            for (int k = 0; k < BW; k++) begin
                if (d_be_i[k]) begin
                    mem[d_idx][k*8 +: 8] <= d_wdata_i[k*8 +: 8];
                end
            end
        end
    end

    // Only the first qualifying tohost write records its code.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            halt_o      <= 1'b0;
            halt_code_o <= '0;
        end else if (d_gnt_o && d_we_i && d_tohost && (|d_be_i) && !halt_o) begin
            halt_o      <= 1'b1;
            halt_code_o <= d_wdata_i;
        end
    end
endmodule
